axi_burst_master: RTL and testbench

//  AXI4 initiator; converts one simple burst request into one AXI4 INCR read or write burst.

---
 rtl/axi_burst_master_pkg.sv | 17 +
 rtl/axi_burst_master.sv | 192 +++++++++++++++++++
 tb/tb_axi_burst_master.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_pkg.sv
// Shared definitions for the AXI4 burst master: FSM encoding and AXI constant codes.
// Imported by axi_burst_master.
package axi_burst_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 initiator: turns one request into one INCR read or write burst, one transaction at a time.
// Data streams are combinational pass-throughs; the slave generates the beat addresses.
module axi_burst_master
   import axi_burst_master_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 30,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 4,
   parameter int AXI_ID     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]            req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  done,
   output logic                  done_err,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [2:0]          AXI_SIZE = 3'($clog2(STRB_WIDTH));
   localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(AXI_ID);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [7:0]              cnt_q;
   logic                    err_q;
   logic                    accept, w_fire, r_fire, last_beat, r_beat_err;

   assign accept     = req_valid && req_ready;
   assign w_fire     = (state == ST_W) && wr_valid && m_axi_wready;
   assign r_fire     = (state == ST_R) && m_axi_rvalid && rd_ready;
   assign last_beat  = (cnt_q == 8'd0);
   // A beat is bad if the slave flags an error or its rlast disagrees with our own count.
   assign r_beat_err = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            cnt_q  <= req_len;
            err_q  <= 1'b0;
         end
         if ((w_fire || r_fire) && !last_beat) cnt_q <= cnt_q - 8'd1;
         if (r_fire && r_beat_err) err_q <= 1'b1;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      req_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      done          = 1'b0;
      done_err      = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = req_wen ? ST_AW : ST_AR;
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_next = ST_W;
         end
         ST_W: begin
            m_axi_wvalid = wr_valid;
            wr_ready     = m_axi_wready;
            if (w_fire && last_beat) state_next = ST_B;
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               done       = 1'b1;
               done_err   = (m_axi_bresp != AXI_RESP_OKAY);
               state_next = ST_IDLE;
            end
         end
         ST_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_next = ST_R;
         end
         ST_R: begin
            rd_valid     = m_axi_rvalid;
            m_axi_rready = rd_ready;
            rd_last      = last_beat;
            if (r_fire && last_beat) begin
               done       = 1'b1;
               done_err   = err_q || r_beat_err;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign rd_data       = m_axi_rdata;
   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = last_beat;

   assign m_axi_awid    = ID_VAL;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = AXI_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0000;
   assign m_axi_awprot  = 3'b000;

   assign m_axi_arid    = ID_VAL;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = AXI_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b000;

   // Simulation-only sanity checks; synthesis ignores immediate assertions.
   always_ff @(posedge clk) begin
      if (!rst && accept)
         assert ((int'(req_addr[11:0]) + ((int'(req_len) + 1) << AXI_SIZE)) <= 4096)
         else $error("axi_burst_master: burst at 0x%0h len %0d crosses a 4KB boundary", req_addr, req_len);
      if (!rst && state == ST_B && m_axi_bvalid)
         assert (m_axi_bid == ID_VAL) else $error("axi_burst_master: unexpected bid %0d", m_axi_bid);
      if (!rst && state == ST_R && m_axi_rvalid)
         assert (m_axi_rid == ID_VAL) else $error("axi_burst_master: unexpected rid %0d", m_axi_rid);
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a randomized AXI slave with fault injection plus a
// request-level memory model that predicts read data and error status.
module tb_axi_burst_master;

   localparam int DW = 32;
   localparam int AW = 30;
   localparam int SW = 4;
   localparam int IW = 4;

   logic          clk, rst;
   logic          req_valid, req_ready, req_wen;
   logic [AW-1:0] req_addr;
   logic [7:0]    req_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] wr_strb;
   logic          rd_valid, rd_ready, rd_last;
   logic [DW-1:0] rd_data;
   logic          done, done_err;
   logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]    m_axi_awlen, m_axi_arlen;
   logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic          m_axi_awlock, m_axi_arlock;
   logic [3:0]    m_axi_awcache, m_axi_arcache;
   logic          m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [SW-1:0] m_axi_wstrb;
   logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic          m_axi_bvalid, m_axi_bready;
   logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

   axi_burst_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .done_err(done_err),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- memories: slave storage and request-level reference ----------------
   logic [31:0] smem [int];
   logic [31:0] rmem [int];

   function automatic logic [31:0] init_word(input int k);
      return 32'(k) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] s_rd(input int k);
      return smem.exists(k) ? smem[k] : init_word(k);
   endfunction

   function automatic logic [31:0] r_rd(input int k);
      return rmem.exists(k) ? rmem[k] : init_word(k);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // ---------------- fault injection and expected request fields ----------------
   bit inj_b_err       = 0;
   int inj_r_err_beat  = -1;
   int early_rlast     = -1;
   bit drop_final_last = 0;
   int cur_addr = 0;
   int cur_len  = 0;

   // ---------------- AXI slave model ----------------
   bit aw_got, b_pend, r_act;
   int s_waddr, s_wlen, s_wbeat, s_raddr, s_rlen, s_rbeat;
   int w_early = 0, wlast_bad = 0, rr_bad = 0;

   initial begin
      {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
      m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      m_axi_bid = '0; m_axi_rid = '0;
      {aw_got, b_pend, r_act} = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            {aw_got, b_pend, r_act} = '0;
         end else begin
            if (m_axi_wvalid && !aw_got) w_early++;
            if (r_act && (m_axi_rready !== rd_ready)) rr_bad++;
            if (m_axi_awvalid && m_axi_awready) begin
               aw_got = 1; s_waddr = int'(m_axi_awaddr); s_wlen = int'(m_axi_awlen); s_wbeat = 0;
               check("aw_addr", m_axi_awaddr, AW'(cur_addr));
               check("aw_len", m_axi_awlen, 8'(cur_len));
               check("aw_ctl", {m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awid},
                     {3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
            end
            if (m_axi_wvalid && m_axi_wready) begin
               smem[(s_waddr >> 2) + s_wbeat] = merge(s_rd((s_waddr >> 2) + s_wbeat), m_axi_wdata, m_axi_wstrb);
               if (m_axi_wlast != (s_wbeat == s_wlen)) wlast_bad++;
               if (s_wbeat == s_wlen) begin b_pend = 1; aw_got = 0; end
               s_wbeat++;
            end
            if (m_axi_bvalid && m_axi_bready) b_pend = 0;
            if (m_axi_arvalid && m_axi_arready) begin
               r_act = 1; s_raddr = int'(m_axi_araddr); s_rlen = int'(m_axi_arlen); s_rbeat = 0;
               check("ar_addr", m_axi_araddr, AW'(cur_addr));
               check("ar_len", m_axi_arlen, 8'(cur_len));
               check("ar_ctl", {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arid},
                     {3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
            end
            if (m_axi_rvalid && m_axi_rready) begin
               if (s_rbeat == s_rlen) r_act = 0;
               s_rbeat++;
            end
         end
         @(posedge clk); #1;
         if (rst) begin
            {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
         end else begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = ($urandom_range(0, 3) != 0);
            m_axi_arready = 1'($urandom_range(0, 1));
            m_axi_bvalid  = b_pend && (m_axi_bvalid || 1'($urandom_range(0, 1)));
            m_axi_bresp   = inj_b_err ? 2'b10 : 2'b00;
            m_axi_rvalid  = r_act && (m_axi_rvalid || 1'($urandom_range(0, 1)));
            m_axi_rdata   = s_rd((s_raddr >> 2) + s_rbeat);
            m_axi_rlast   = r_act && (((s_rbeat == s_rlen) && !drop_final_last) || (s_rbeat == early_rlast));
            m_axi_rresp   = (r_act && s_rbeat == inj_r_err_beat) ? 2'b10 : 2'b00;
         end
      end
   end

   // ---------------- requester side ----------------
   logic [31:0] wq_data [$];
   logic [3:0]  wq_strb [$];
   logic [31:0] rd_got  [$];

   // rd_mode: 0 random, 1 toggle every cycle, 2 always ready. abort_beat>=0 resets mid-write.
   task automatic do_req(input bit wen, input int addr, input int len, input int rd_mode,
                         input int abort_beat, input bit exp_err, input string tag);
      int  widx = 0, cyc = 0;
      bit  acc = 0, fin = 0, first = 1, w_fired = 0, got_err = 0;
      bit  lasts [$];
      cur_addr = addr; cur_len = len;
      rd_got.delete();
      while (!fin && cyc < 3000) begin
         @(posedge clk); #1;
         req_valid = !acc; req_wen = wen; req_addr = AW'(addr); req_len = 8'(len);
         if (abort_beat >= 0 && widx == abort_beat) begin
            rst = 1; req_valid = 0; wr_valid = 0;
            @(posedge clk); @(negedge clk);
            check({tag, "_rst_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                         m_axi_rready, rd_valid, done, done_err}, 8'h00);
            check({tag, "_rst_ready"}, req_ready, 1'b1);
            @(posedge clk); #1;
            rst = 0;
            return;
         end
         if (wen && acc && widx <= len) begin
            wr_valid = (wr_valid && !w_fired) || 1'($urandom_range(0, 1));
            wr_data  = wq_data[widx];
            wr_strb  = wq_strb[widx];
         end else begin
            wr_valid = 0;
         end
         rd_ready = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? 1'(cyc & 1) : 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
         if (first) check({tag, "_req_ready"}, req_ready, 1'b1);
         first = 0; w_fired = 0;
         if (req_valid && req_ready) acc = 1;
         if (wr_valid && wr_ready) begin widx++; w_fired = 1; end
         if (rd_valid && rd_ready) begin rd_got.push_back(rd_data); lasts.push_back(rd_last); end
         if (done) begin fin = 1; got_err = done_err; end
      end
      wr_valid = 0;
      if (!fin) begin
         check({tag, "_timeout"}, 1'b0, 1'b1);
         return;
      end
      check({tag, "_done_err"}, got_err, exp_err);
      if (wen) begin
         check({tag, "_wbeats"}, widx, len + 1);
         for (int i = 0; i <= len; i++)
            rmem[(addr >> 2) + i] = merge(r_rd((addr >> 2) + i), wq_data[i], wq_strb[i]);
      end else begin
         check({tag, "_rbeats"}, rd_got.size(), len + 1);
         for (int i = 0; i <= len && i < rd_got.size(); i++) begin
            check({tag, "_rdata"}, rd_got[i], r_rd((addr >> 2) + i));
            check({tag, "_rd_last"}, lasts[i], (i == len));
         end
      end
   endtask

   task automatic preload(input int addr, input logic [31:0] v);
      smem[addr >> 2] = v;
      rmem[addr >> 2] = v;
   endtask

   initial begin
      rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_len = '0;
      wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, rd_valid, done, done_err}, 8'h00);
      @(posedge clk); #1;
      rst = 0;

      // Directed: read of preloaded words
      for (int i = 0; i < 4; i++) preload(32'h100 + 4 * i, 32'hA0 + 32'(i));
      do_req(0, 32'h100, 3, 2, -1, 0, "t1");
      for (int i = 0; i < 4; i++) check("t1_value", rd_got[i], 32'hA0 + 32'(i));

      // Directed: partial-strobe write then readback
      preload(32'h200, 32'hCAFEF00D);
      preload(32'h204, 32'hDEADBEEF);
      wq_data = '{32'h11223344, 32'h55667788};
      wq_strb = '{4'hF, 4'h3};
      do_req(1, 32'h200, 1, 0, -1, 0, "t2w");
      do_req(0, 32'h200, 1, 2, -1, 0, "t2r");
      check("t2_word0", rd_got[0], 32'h11223344);
      check("t2_word1", rd_got[1], 32'hDEAD7788);

      // Directed: toggling rd_ready on an 8-beat read
      rr_bad = 0;
      do_req(0, 32'h300, 7, 1, -1, 0, "t3");
      check("t3_rready_mirror", rr_bad, 0);

      // Directed: premature rlast
      early_rlast = 2;
      do_req(0, 32'h400, 3, 0, -1, 1, "t4");
      early_rlast = -1;

      // Directed: reset during the third write beat, then a clean read
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i < 6; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
      do_req(1, 32'h3000, 5, 0, 2, 0, "t5w");
      do_req(0, 32'h500, 2, 0, -1, 0, "t5r");

      // Directed: back-to-back write then read of the same word
      wq_data = '{32'h600DCAFE};
      wq_strb = '{4'hF};
      do_req(1, 32'h700, 0, 0, -1, 0, "t6w");
      do_req(0, 32'h700, 0, 2, -1, 0, "t6r");
      check("t6_value", rd_got[0], 32'h600DCAFE);

      // Randomized traffic with occasional faults
      for (int n = 0; n < 40; n++) begin
         bit wen;
         int len, addr, f;
         bit exp_err;
         wen  = 1'($urandom_range(0, 1));
         len  = $urandom_range(0, 15);
         addr = $urandom_range(0, 32'h7FF) * 4;
         if ((addr & 32'hFFF) + (len + 1) * 4 > 4096) addr = addr - (len + 1) * 4;
         f = $urandom_range(0, 9);
         exp_err = 0;
         if (wen) begin
            wq_data.delete(); wq_strb.delete();
            for (int i = 0; i <= len; i++) begin
               wq_data.push_back($urandom);
               wq_strb.push_back(4'($urandom_range(0, 15)));
            end
            if (f == 0) begin inj_b_err = 1; exp_err = 1; end
         end else begin
            if (f == 0) begin inj_r_err_beat = $urandom_range(0, len); exp_err = 1; end
            if (f == 1 && len > 0) begin early_rlast = $urandom_range(0, len - 1); exp_err = 1; end
            if (f == 2) begin drop_final_last = 1; exp_err = 1; end
         end
         do_req(wen, addr, len, 0, -1, exp_err, wen ? "rnd_w" : "rnd_r");
         inj_b_err = 0; inj_r_err_beat = -1; early_rlast = -1; drop_final_last = 0;
      end

      check("w_before_aw", w_early, 0);
      check("wlast_position", wlast_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
